midi_event_parser: RTL

Byte-level MIDI receive parser sitting between the UART receiver and `midi_coordinator`. It consumes raw MIDI bytes, tracks running status, and emits one-cycle note-on/note-off events carrying the note's playback rate (`cycles_between_samples`) in exactly the form the coordinator consumes. All non-note traffic is skipped without disturbing parse state.

---
 rtl/midi_pkg.sv | 65 ++++++
 rtl/midi_event_parser_note_period_rom.sv | 20 ++
 rtl/midi_event_parser.sv | 118 +++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, parse states and the note playback period table.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF       = 4'h8;
    localparam logic [3:0] NOTE_ON        = 4'h9;
    localparam logic [3:0] POLY_PRESSURE  = 4'hA;
    localparam logic [3:0] CONTROL_CHANGE = 4'hB;
    localparam logic [3:0] PROGRAM_CHANGE = 4'hC;
    localparam logic [3:0] CHAN_PRESSURE  = 4'hD;
    localparam logic [3:0] PITCH_BEND     = 4'hE;

    localparam logic [7:0] SYSEX_START    = 8'hF0;
    localparam logic [7:0] REALTIME_FIRST = 8'hF8;

    localparam int unsigned PERIOD_W = 24;
    localparam int unsigned NOTES    = 128;
    localparam int unsigned CLK_HZ   = 100_000_000;
    localparam int unsigned WAVE_LEN = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA1,
        ST_DATA2,
        ST_SYSEX
    } parse_state_t;

    typedef logic [PERIOD_W-1:0] period_table_t [NOTES];

    // Clock cycles per wavetable sample; octave 9 frequencies in mHz, halved per octave down.
    function automatic logic [PERIOD_W-1:0] note_period(input int unsigned n);
        logic [63:0] top_mhz;
        int unsigned oct;
        oct = n / 12;
        case (n % 12)
            0:       top_mhz = 64'd8372018;
            1:       top_mhz = 64'd8869844;
            2:       top_mhz = 64'd9397273;
            3:       top_mhz = 64'd9956063;
            4:       top_mhz = 64'd10548082;
            5:       top_mhz = 64'd11175303;
            6:       top_mhz = 64'd11839822;
            7:       top_mhz = 64'd12543854;
            8:       top_mhz = 64'd13289750;
            9:       top_mhz = 64'd14080000;
            10:      top_mhz = 64'd14917240;
            default: top_mhz = 64'd15804266;
        endcase
        return PERIOD_W'(((64'(CLK_HZ) * 64'd1000) << (10 - oct)) / (top_mhz * 64'(WAVE_LEN)));
    endfunction

    function automatic period_table_t build_period_table();
        period_table_t t;
        for (int unsigned i = 0; i < NOTES; i++) begin
            t[i] = note_period(i);
        end
        return t;
    endfunction

    localparam period_table_t PERIOD_TABLE = build_period_table();

    function automatic logic is_two_byte(input logic [3:0] kind);
        return (kind != PROGRAM_CHANGE) && (kind != CHAN_PRESSURE);
    endfunction

endpackage

// File: rtl/midi_event_parser_note_period_rom.sv
// Synchronous one-cycle lookup of the note period table.
module note_period_rom
    import midi_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                en,
    input  logic [6:0]          addr,
    output logic [PERIOD_W-1:0] period
);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            period <= '0;
        end else if (en) begin
            period <= PERIOD_TABLE[addr];
        end
    end

endmodule

// File: rtl/midi_event_parser.sv
// MIDI byte parser with running status; emits registered note-on/off events with playback period.
module midi_event_parser
    import midi_pkg::*;
#(
    parameter int unsigned CHANNEL = 16
)(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid_in,
    output logic                valid_out,
    output logic                is_note_on_out,
    output logic [6:0]          note_out,
    output logic [6:0]          velocity_out,
    output logic [3:0]          channel_out,
    output logic [PERIOD_W-1:0] cycles_between_samples,
    output logic [7:0]          dropped_count
);

    parse_state_t        state, next_state;
    logic [7:0]          status_q, status_d;
    logic [6:0]          data1_q, data1_d;
    logic                emit_c, note_on_c, drop_c, rom_en_c;
    logic                chan_match_c, is_note_c;
    logic [PERIOD_W-1:0] rom_period;

    note_period_rom u_rom (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (rom_en_c),
        .addr   (byte_in[6:0]),
        .period (rom_period)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= ST_IDLE;
            status_q <= '0;
            data1_q  <= '0;
        end else begin
            state    <= next_state;
            status_q <= status_d;
            data1_q  <= data1_d;
        end
    end

    assign chan_match_c = (CHANNEL >= 16) || (status_q[3:0] == 4'(CHANNEL));
    assign is_note_c    = (status_q[7:4] == NOTE_ON) || (status_q[7:4] == NOTE_OFF);

    // Real-time bytes fall through with every default held.
    always_comb begin
        next_state = state;
        status_d   = status_q;
        data1_d    = data1_q;
        emit_c     = 1'b0;
        note_on_c  = 1'b0;
        drop_c     = 1'b0;
        rom_en_c   = 1'b0;
        if (byte_valid_in && (byte_in < REALTIME_FIRST)) begin
            if (byte_in[7]) begin
                if (byte_in < SYSEX_START) begin
                    status_d   = byte_in;
                    next_state = ST_DATA1;
                end else if (byte_in == SYSEX_START) begin
                    status_d   = '0;
                    next_state = ST_SYSEX;
                end else begin
                    status_d   = '0;
                    next_state = ST_IDLE;
                end
            end else begin
                unique case (state)
                    ST_IDLE:  drop_c = 1'b1;
                    ST_DATA1: begin
                        data1_d  = byte_in[6:0];
                        rom_en_c = 1'b1;
                        // One-byte messages (program/pressure) are never notes.
                        if (is_two_byte(status_q[7:4])) begin
                            next_state = ST_DATA2;
                        end
                    end
                    ST_DATA2: begin
                        next_state = ST_DATA1;
                        emit_c     = is_note_c && chan_match_c;
                        note_on_c  = (status_q[7:4] == NOTE_ON) && (byte_in[6:0] != 7'd0);
                    end
                    ST_SYSEX: ;
                    default:  next_state = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_out              <= 1'b0;
            is_note_on_out         <= 1'b0;
            note_out               <= '0;
            velocity_out           <= '0;
            channel_out            <= '0;
            cycles_between_samples <= '0;
            dropped_count          <= '0;
        end else begin
            valid_out <= emit_c;
            if (emit_c) begin
                is_note_on_out         <= note_on_c;
                note_out               <= data1_q;
                velocity_out           <= byte_in[6:0];
                channel_out            <= status_q[3:0];
                cycles_between_samples <= rom_period;
            end
            if (drop_c && (dropped_count != 8'hFF)) begin
                dropped_count <= dropped_count + 8'd1;
            end
        end
    end

endmodule
